// File: rtl/bf_bus_pkg.sv
// Shared types and constants for the BF external memory bus sequencer.
// Used by both the BF core and the chip top.
package bf_bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_DRIVE,
        WR_TURN
    } bus_state_e;

    localparam logic [7:0] OE_WRITE = 8'hFF;
    localparam logic [7:0] OE_READ  = 8'h00;

endpackage

// File: rtl/bf_mem_bus_ctrl.sv
// External memory bus sequencer: one read or write at a time from the BF core,
// driving address/data/oe pins and returning a one-cycle response pulse.
module bf_mem_bus_ctrl #(
    parameter int ADDR_W    = bf_bus_pkg::ADDR_W_DEF,
    parameter int DATA_W    = bf_bus_pkg::DATA_W_DEF,
    parameter int RD_WAIT   = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic [DATA_W-1:0] bus_oe
);
    import bf_bus_pkg::*;

    localparam int CNT_MAX = (RD_WAIT > WR_CYCLES) ? RD_WAIT : WR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DATA_W-1:0] OE_ON  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] OE_OFF = '0;

    bus_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             cnt_zero;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & ena & req_ready;
    assign cnt_zero  = (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = req_we ? WR_DRIVE : bf_bus_pkg::RD_WAIT;
            bf_bus_pkg::RD_WAIT: if (cnt_zero) state_nxt = IDLE;
            WR_DRIVE: if (cnt_zero) state_nxt = WR_TURN;
            WR_TURN:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // All bus/response outputs are registered; the counter is only loaded in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_addr  <= '0;
            bus_dout  <= '0;
            bus_oe    <= OE_OFF;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_addr <= req_addr;
                        if (req_we) begin
                            cnt      <= CNT_W'(WR_CYCLES - 1);
                            bus_dout <= req_wdata;
                            bus_oe   <= OE_ON;
                        end else begin
                            cnt      <= CNT_W'(RD_WAIT - 1);
                            bus_oe   <= OE_OFF;
                        end
                    end
                end
                bf_bus_pkg::RD_WAIT: begin
                    if (cnt_zero) begin
                        rsp_rdata <= bus_din;
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_DRIVE: begin
                    // Drop oe one cycle ahead of IDLE so the turnaround cycle is oe=0.
                    if (cnt_zero) bus_oe <= OE_OFF;
                    else          cnt    <= cnt - 1'b1;
                end
                WR_TURN: begin
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b1;
                end
                default: bus_oe <= OE_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_mem_bus_ctrl.sv
// Self-checking bench for bf_mem_bus_ctrl: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bf_mem_bus_ctrl;
    localparam int RDW = 2;
    localparam int WRC = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, req_valid, req_we;
    logic [7:0] req_addr, req_wdata, bus_din;
    logic       req_ready, rsp_valid, rsp_we;
    logic [7:0] rsp_rdata, bus_addr, bus_dout, bus_oe;

    bf_mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(RDW), .WR_CYCLES(WRC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: k counts cycles since the accept edge (k=1 is T+1).
    bit         m_busy = 0, m_we = 0, m_rsp = 0, m_rsp_we = 0;
    int         m_k = 0;
    logic [7:0] m_bus_addr = 0, m_bus_dout = 0, m_rdata = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready",     32'(req_ready), 32'(!m_busy));
            chk("bus_oe",    32'(bus_oe),    (m_busy && m_we && m_k <= WRC) ? 32'hFF : 32'h00);
            chk("bus_addr",  32'(bus_addr),  32'(m_bus_addr));
            chk("bus_dout",  32'(bus_dout),  32'(m_bus_dout));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            if (m_rsp) chk("rsp_we", 32'(rsp_we), 32'(m_rsp_we));
        end
        if (!rst_n) begin
            m_busy = 0; m_we = 0; m_rsp = 0; m_rsp_we = 0; m_k = 0;
            m_bus_addr = 0; m_bus_dout = 0; m_rdata = 0;
        end else begin
            m_rsp = 0;
            if (m_busy) begin
                if (!m_we && m_k == RDW) begin
                    m_rdata = bus_din; m_busy = 0; m_rsp = 1; m_rsp_we = 0;
                end else if (m_we && m_k == WRC + 1) begin
                    m_busy = 0; m_rsp = 1; m_rsp_we = 1;
                end else begin
                    m_k++;
                end
            end else if (req_valid && ena) begin
                m_busy = 1; m_k = 1; m_we = req_we; m_bus_addr = req_addr;
                if (req_we) m_bus_dout = req_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    bit acc_rsp;

    // Present a request and return at T+1 (just after the accept edge).
    task automatic accept(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        bit done = 0;
        step();
        req_valid = 1; ena = 1; req_we = we; req_addr = addr; req_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin done = 1; acc_rsp = rsp_valid; end
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    initial begin
        rst_n = 0; ena = 0; req_valid = 0; req_we = 0;
        req_addr = 0; req_wdata = 0; bus_din = 0;
        step(); chk_en = 1;
        step(); rst_n = 1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_addr",  32'(bus_addr), 0);
        chk("rst_oe",    32'(bus_oe), 0);
        chk("rst_rsp",   32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);

        // Request held with ena low is never taken
        step(); req_valid = 1; ena = 0; req_addr = 8'h99;
        repeat (5) begin
            @(negedge clk);
            chk("ena0_ready", 32'(req_ready), 1);
            chk("ena0_addr",  32'(bus_addr), 0);
        end
        step(); req_valid = 0;

        // Read 3C -> A5
        bus_din = 8'hA5;
        accept(0, 8'h3C, 8'h00);
        @(negedge clk); chk("rd_addr", 32'(bus_addr), 32'h3C); chk("rd_oe", 32'(bus_oe), 0);
        chk("rd_rsp_t1", 32'(rsp_valid), 0);
        step(); @(negedge clk); chk("rd_rsp_t2", 32'(rsp_valid), 0);
        step(); @(negedge clk); chk("rd_rsp_t3", 32'(rsp_valid), 1);
        chk("rd_data", 32'(rsp_rdata), 32'hA5); chk("rd_we", 32'(rsp_we), 0);

        // Write 10 <- 5A
        accept(1, 8'h10, 8'h5A);
        @(negedge clk); chk("wr_oe_t1", 32'(bus_oe), 32'hFF); chk("wr_dout_t1", 32'(bus_dout), 32'h5A);
        step(); @(negedge clk); chk("wr_oe_t2", 32'(bus_oe), 32'hFF); chk("wr_dout_t2", 32'(bus_dout), 32'h5A);
        step(); @(negedge clk); chk("wr_oe_t3", 32'(bus_oe), 0); chk("wr_rsp_t3", 32'(rsp_valid), 0);
        step(); @(negedge clk); chk("wr_rsp_t4", 32'(rsp_valid), 1); chk("wr_we", 32'(rsp_we), 1);
        chk("wr_rdata_kept", 32'(rsp_rdata), 32'hA5);

        // Back-to-back write then read, read accepted in the write's rsp cycle
        accept(1, 8'h77, 8'hC3);
        bus_din = 8'h9E;
        accept(0, 8'h44, 8'h00);
        chk("b2b_acc_in_rsp", 32'(acc_rsp), 1);
        @(negedge clk); chk("b2b_addr", 32'(bus_addr), 32'h44); chk("b2b_oe", 32'(bus_oe), 0);
        step(); step(); @(negedge clk); chk("b2b_rsp", 32'(rsp_valid), 1);
        chk("b2b_data", 32'(rsp_rdata), 32'h9E);

        // Reset at T+1 of a write
        accept(1, 8'h20, 8'h11);
        rst_n = 0;
        step(); rst_n = 1;
        @(negedge clk); chk("rstw_oe", 32'(bus_oe), 0); chk("rstw_ready", 32'(req_ready), 1);
        repeat (6) begin @(negedge clk); chk("rstw_no_rsp", 32'(rsp_valid), 0); end
        bus_din = 8'h3B;
        accept(0, 8'h21, 8'h00);
        step(); step(); @(negedge clk); chk("rstw_rd_rsp", 32'(rsp_valid), 1);
        chk("rstw_rd_data", 32'(rsp_rdata), 32'h3B);

        // ena dropped at T+1 of a read
        bus_din = 8'h6D;
        accept(0, 8'h55, 8'h00);
        ena = 0;
        step(); @(negedge clk); chk("ena_drop_t2", 32'(rsp_valid), 0);
        step(); @(negedge clk); chk("ena_drop_rsp", 32'(rsp_valid), 1);
        chk("ena_drop_data", 32'(rsp_rdata), 32'h6D);

        // Randomized traffic, model-checked every cycle
        repeat (600) begin
            step();
            req_valid = 1'($urandom % 2);
            ena       = 1'(($urandom % 4) != 0);
            req_we    = 1'($urandom % 2);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            bus_din   = 8'($urandom);
            rst_n     = 1'(($urandom % 80) != 0);
        end
        step(); rst_n = 1; req_valid = 0;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
